hd63701_int_ctrl: RTL and testbench
===================================

// Module: hd63701_int_ctrl
// PURPOSE
// Interrupt priority controller feeding the HD63701 sequencer. Synchronises external NMI/IRQ1,
// edge-latches NMI, merges on-chip IRQ2 sources (timer ICF/OCF/TOF, SCI), selects the winner and
// presents one request + vector byte to the sequencer, holding the vector stable through a
// start/done acknowledge handshake. Also drives the WAI/SLEEP wake line.
// PARAMETERS
// SYNC_STAGES  2  flip-flop stages on NMI_PIN and IRQ1_PIN (1..3)
// NMI_EDGE     1  1 = NMI latched on rising edge of synchronised pin; 0 = level (test only)
// PORTS
// CLK       in   1  system clock, all state on posedge
// RST       in   1  asynchronous reset, active-high
// EN        in   1  clock enable; state and sync chains advance only when EN=1
// NMI_PIN   in   1  external NMI, active-high, asynchronous
// IRQ1_PIN  in   1  external IRQ1, active-high level, asynchronous
// ICF_REQ   in   1  timer input-capture flag AND its enable (level, cleared by peripheral)
// OCF_REQ   in   1  timer output-compare flag AND enable (level)
// TOF_REQ   in   1  timer overflow flag AND enable (level)
// SCI_REQ   in   1  SCI interrupt (level)
// IMASK     in   1  CCR I bit; 1 masks all maskable sources
// ACK_START in   1  sequencer has begun stacking for current request (1-cycle pulse, EN-qualified)
// ACK_DONE  in   1  sequencer has fetched vector (1-cycle pulse, EN-qualified)
// INT_REQ   out  1  interrupt request to sequencer
// INT_VECT  out  8  low byte of vector address ($FC,$F8,$F6,$F4,$F2,$F0)
// WAKE      out  1  any source pending irrespective of IMASK except masked ones; see below
// NMI_PEND  out  1  NMI latch state (debug/status)
// BEHAVIOUR
// - Reset: INT_REQ=0, INT_VECT=$00, WAKE=0, NMI_PEND=0, sync chains=0, state=IDLE.
// - Sync: NMI_PIN/IRQ1_PIN pass SYNC_STAGES flops; on-chip *_REQ used directly (already CLK-domain).
// - NMI latch: set on 0->1 of synced NMI (NMI_EDGE=1) or while synced NMI=1 (NMI_EDGE=0);
//   cleared only on ACK_DONE while locked vector=$FC. Set and clear same cycle -> set wins
//   (new edge is not lost). NMI is never masked by IMASK.
// - Maskable set M = {IRQ1 synced, ICF, OCF, TOF, SCI} gated by !IMASK.
// - Priority (fixed): NMI $FC > IRQ1 $F8 > ICF $F6 > OCF $F4 > TOF $F2 > SCI $F0.
// - FSM (registered, 3 states):
//   IDLE: any active -> PEND, INT_REQ=1, INT_VECT=winner (next cycle; latency 1 clk from synced source).
//   PEND: INT_VECT re-evaluated every cycle (higher source preempts, e.g. IRQ1->NMI upgrades to $FC);
//         all sources drop -> IDLE, INT_REQ=0, INT_VECT held; ACK_START -> LOCK.
//   LOCK: INT_VECT frozen; INT_REQ stays 1; source changes ignored; ACK_DONE -> IDLE (INT_REQ=0
//         next cycle, re-arbitrate the cycle after). ACK_START in LOCK ignored.
// - ACK_DONE in IDLE/PEND ignored. ACK_START and source drop same cycle -> LOCK (ack wins).
// - WAKE = NMI latch | OR(M) combinationally from registered/synced terms; used by SLEEP/WAI exit.
// - Maskable sources are not latched: a level that clears before ACK_START withdraws the request.
// - RST mid-handshake -> immediate IDLE, NMI latch cleared, pending edges lost.
// - EN=0 freezes everything including edge detect (an NMI pulse shorter than EN spacing may be missed).
// TESTING
// 1. Reset, IRQ1_PIN=1, IMASK=0 -> INT_REQ=1, INT_VECT=$F8 after SYNC_STAGES+1 clks.
// 2. OCF_REQ=1 & TOF_REQ=1 -> $F4; ACK_START; drop OCF -> vector stays $F4 until ACK_DONE, then $F2.
// 3. IRQ1 pending (PEND), NMI rising edge -> vector upgrades to $FC before ACK_START; IMASK=1 no effect.
// 4. NMI held high across ACK_DONE -> latch clears, INT_REQ=0, no re-trigger until NMI low then high.
// 5. IMASK=1 with SCI_REQ=1 -> INT_REQ=0, WAKE=0; IMASK->0 -> INT_REQ=1, $F0 next clk.
// 6. RST pulse during LOCK with NMI latched -> all outputs to reset values asynchronously.

Source files
------------

// File: rtl/hd63701_int_ctrl.sv
// Interrupt priority controller for the HD63701 sequencer: synchronises external pins,
// edge-latches NMI, arbitrates fixed-priority sources and runs the start/done vector handshake.
module hd63701_int_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter bit NMI_EDGE    = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_nmi_pin,
  input  logic       i_irq1_pin,
  input  logic       i_icf_req,
  input  logic       i_ocf_req,
  input  logic       i_tof_req,
  input  logic       i_sci_req,
  input  logic       i_imask,
  input  logic       i_ack_start,
  input  logic       i_ack_done,
  output logic       o_int_req,
  output logic [7:0] o_int_vect,
  output logic       o_wake,
  output logic       o_nmi_pend
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;

  localparam logic [7:0] V_NMI  = 8'hFC;
  localparam logic [7:0] V_IRQ1 = 8'hF8;
  localparam logic [7:0] V_ICF  = 8'hF6;
  localparam logic [7:0] V_OCF  = 8'hF4;
  localparam logic [7:0] V_TOF  = 8'hF2;
  localparam logic [7:0] V_SCI  = 8'hF0;

  logic [SYNC_STAGES-1:0] r_nmi_sync;
  logic [SYNC_STAGES-1:0] r_irq1_sync;
  logic                   r_nmi_prev;
  logic                   r_nmi_latch;
  logic [1:0]             r_state;
  logic                   r_int_req;
  logic [7:0]             r_int_vect;

  logic       w_nmi_s;
  logic       w_irq1_s;
  logic       w_nmi_set;
  logic       w_nmi_clr;
  logic       w_nmi_act;
  logic [4:0] w_mask;
  logic       w_any;
  logic [7:0] w_win_vect;
  logic [1:0] w_state_nx;
  logic       w_req_nx;
  logic [7:0] w_vect_nx;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_nmi_sync  <= '0;
      r_irq1_sync <= '0;
    end else if (i_en) begin
      r_nmi_sync[0]  <= i_nmi_pin;
      r_irq1_sync[0] <= i_irq1_pin;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_nmi_sync[i]  <= r_nmi_sync[i-1];
        r_irq1_sync[i] <= r_irq1_sync[i-1];
      end
    end
  end

  assign w_nmi_s  = r_nmi_sync[SYNC_STAGES-1];
  assign w_irq1_s = r_irq1_sync[SYNC_STAGES-1];

  always_comb begin
    if (NMI_EDGE) begin
      w_nmi_set = w_nmi_s & ~r_nmi_prev;
    end else begin
      w_nmi_set = w_nmi_s;
    end
  end

  // Only the completion of an NMI service clears the latch; a coincident new edge still sets it.
  assign w_nmi_clr = i_ack_done & (r_state == S_LOCK) & (r_int_vect == V_NMI);
  assign w_nmi_act = r_nmi_latch | w_nmi_set;
  assign w_mask    = {w_irq1_s, i_icf_req, i_ocf_req, i_tof_req, i_sci_req} & {5{~i_imask}};
  assign w_any     = w_nmi_act | (|w_mask);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_nmi_prev  <= 1'b0;
      r_nmi_latch <= 1'b0;
    end else if (i_en) begin
      r_nmi_prev  <= w_nmi_s;
      r_nmi_latch <= w_nmi_set | (r_nmi_latch & ~w_nmi_clr);
    end
  end

  always_comb begin
    if (w_nmi_act) begin
      w_win_vect = V_NMI;
    end else if (w_mask[4]) begin
      w_win_vect = V_IRQ1;
    end else if (w_mask[3]) begin
      w_win_vect = V_ICF;
    end else if (w_mask[2]) begin
      w_win_vect = V_OCF;
    end else if (w_mask[1]) begin
      w_win_vect = V_TOF;
    end else begin
      w_win_vect = V_SCI;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_req_nx   = r_int_req;
    w_vect_nx  = r_int_vect;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nx = S_PEND;
          w_req_nx   = 1'b1;
          w_vect_nx  = w_win_vect;
        end else begin
          w_req_nx = 1'b0;
        end
      end
      S_PEND: begin
        // An acknowledge freezes the vector already presented, even if sources drop this cycle.
        if (i_ack_start) begin
          w_state_nx = S_LOCK;
        end else if (w_any) begin
          w_vect_nx = w_win_vect;
        end else begin
          w_state_nx = S_IDLE;
          w_req_nx   = 1'b0;
        end
      end
      S_LOCK: begin
        if (i_ack_done) begin
          w_state_nx = S_IDLE;
          w_req_nx   = 1'b0;
        end else begin
          w_req_nx = 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_req_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_int_req  <= 1'b0;
      r_int_vect <= 8'h00;
    end else if (i_en) begin
      r_state    <= w_state_nx;
      r_int_req  <= w_req_nx;
      r_int_vect <= w_vect_nx;
    end
  end

  assign o_int_req  = r_int_req;
  assign o_int_vect = r_int_vect;
  assign o_nmi_pend = r_nmi_latch;
  assign o_wake     = r_nmi_latch | (|w_mask);

endmodule

// File: tb/tb_hd63701_int_ctrl.sv
// Self-checking bench for hd63701_int_ctrl: directed scenarios then randomized traffic,
// all compared against a cycle-level behavioural model of the interrupt rules.
module tb_hd63701_int_ctrl;

  localparam int SYNC = 2;

  logic       clk, rst, en;
  logic       nmi_pin, irq1_pin, icf, ocf, tof, sci, imask, ack_start, ack_done;
  logic       int_req, wake, nmi_pend;
  logic [7:0] int_vect;

  int n_pass  = 0;
  int n_total = 0;

  hd63701_int_ctrl #(.SYNC_STAGES(SYNC), .NMI_EDGE(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .i_nmi_pin(nmi_pin), .i_irq1_pin(irq1_pin),
    .i_icf_req(icf), .i_ocf_req(ocf), .i_tof_req(tof), .i_sci_req(sci),
    .i_imask(imask), .i_ack_start(ack_start), .i_ack_done(ack_done),
    .o_int_req(int_req), .o_int_vect(int_vect), .o_wake(wake), .o_nmi_pend(nmi_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pin delay lines, NMI latch, and the request/lock handshake
  bit         mq_nmi[$];
  bit         mq_irq[$];
  bit         m_prev, m_latch, m_req, m_locked;
  logic [7:0] m_vect;
  logic [7:0] vtab [6] = '{8'hFC, 8'hF8, 8'hF6, 8'hF4, 8'hF2, 8'hF0};

  task automatic model_reset();
    mq_nmi.delete();
    mq_irq.delete();
    for (int i = 0; i < SYNC; i++) begin
      mq_nmi.push_back(1'b0);
      mq_irq.push_back(1'b0);
    end
    m_prev = 1'b0; m_latch = 1'b0; m_req = 1'b0; m_locked = 1'b0; m_vect = 8'h00;
  endtask

  task automatic model_step();
    bit s_nmi, s_irq, nmi_set, clr, any;
    bit src [6];
    int win;
    if (!en) return;
    s_nmi   = mq_nmi[0];
    s_irq   = mq_irq[0];
    nmi_set = s_nmi && !m_prev;
    src     = '{m_latch || nmi_set, s_irq && !imask, icf && !imask,
                ocf && !imask, tof && !imask, sci && !imask};
    win = -1;
    for (int i = 5; i >= 0; i--) if (src[i]) win = i;
    any = (win >= 0);
    clr = 1'b0;
    if (m_locked) begin
      if (ack_done) begin
        clr      = (m_vect == 8'hFC);
        m_locked = 1'b0;
        m_req    = 1'b0;
      end
    end else if (m_req) begin
      if (ack_start) m_locked = 1'b1;
      else if (any)  m_vect   = vtab[win];
      else           m_req    = 1'b0;
    end else if (any) begin
      m_req  = 1'b1;
      m_vect = vtab[win];
    end
    m_latch = nmi_set || (m_latch && !clr);
    m_prev  = s_nmi;
    mq_nmi.push_back(nmi_pin); void'(mq_nmi.pop_front());
    mq_irq.push_back(irq1_pin); void'(mq_irq.pop_front());
  endtask

  function automatic bit model_wake();
    return m_latch || (!imask && (mq_irq[0] || icf || ocf || tof || sci));
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "/req"},  {7'd0, int_req},  {7'd0, m_req});
    chk({tag, "/vect"}, int_vect,         m_vect);
    chk({tag, "/pend"}, {7'd0, nmi_pend}, {7'd0, m_latch});
    chk({tag, "/wake"}, {7'd0, wake},     {7'd0, model_wake()});
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk_model(tag);
    ack_start = 1'b0;
    ack_done  = 1'b0;
  endtask

  task automatic clear_inputs();
    en = 1'b1; nmi_pin = 1'b0; irq1_pin = 1'b0; icf = 1'b0; ocf = 1'b0; tof = 1'b0;
    sci = 1'b0; imask = 1'b0; ack_start = 1'b0; ack_done = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    clear_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk({tag, "/rst_req"},  {7'd0, int_req},  8'h00);
    chk({tag, "/rst_vect"}, int_vect,         8'h00);
    chk({tag, "/rst_wake"}, {7'd0, wake},     8'h00);
    chk({tag, "/rst_pend"}, {7'd0, nmi_pend}, 8'h00);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();

    // 1: IRQ1 after SYNC+1 clocks
    do_reset("t1");
    irq1_pin = 1'b1;
    tick("t1a"); tick("t1b");
    chk("t1_early_req", {7'd0, int_req}, 8'h00);
    tick("t1c");
    chk("t1_req", {7'd0, int_req}, 8'h01);
    chk("t1_vect", int_vect, 8'hF8);

    // 2: OCF+TOF, vector frozen through lock, then TOF
    do_reset("t2");
    ocf = 1'b1; tof = 1'b1;
    tick("t2a");
    chk("t2_vect_ocf", int_vect, 8'hF4);
    ack_start = 1'b1;
    tick("t2b");
    ocf = 1'b0;
    tick("t2c");
    chk("t2_locked", int_vect, 8'hF4);
    chk("t2_locked_req", {7'd0, int_req}, 8'h01);
    ack_done = 1'b1;
    tick("t2d");
    chk("t2_done_req", {7'd0, int_req}, 8'h00);
    tick("t2e");
    chk("t2_vect_tof", int_vect, 8'hF2);

    // 3: IRQ1 pending upgraded by NMI edge; IMASK does not mask NMI
    do_reset("t3");
    irq1_pin = 1'b1;
    tick("t3a"); tick("t3b"); tick("t3c");
    nmi_pin = 1'b1;
    tick("t3d"); tick("t3e");
    chk("t3_pre_nmi", int_vect, 8'hF8);
    tick("t3f");
    chk("t3_nmi_vect", int_vect, 8'hFC);
    chk("t3_nmi_pend", {7'd0, nmi_pend}, 8'h01);
    imask = 1'b1;
    tick("t3g");
    chk("t3_imask_vect", int_vect, 8'hFC);
    chk("t3_imask_req", {7'd0, int_req}, 8'h01);

    // 4: NMI held across ACK_DONE clears latch; needs a fresh edge to retrigger
    ack_start = 1'b1;
    tick("t4a");
    ack_done = 1'b1;
    tick("t4b");
    chk("t4_done_req", {7'd0, int_req}, 8'h00);
    chk("t4_done_pend", {7'd0, nmi_pend}, 8'h00);
    tick("t4c"); tick("t4d");
    chk("t4_no_retrig", {7'd0, int_req}, 8'h00);
    nmi_pin = 1'b0;
    tick("t4e"); tick("t4f"); tick("t4g");
    nmi_pin = 1'b1;
    tick("t4h"); tick("t4i");
    chk("t4_not_yet", {7'd0, int_req}, 8'h00);
    tick("t4j");
    chk("t4_retrig_vect", int_vect, 8'hFC);

    // 5: IMASK hides SCI from both request and wake
    do_reset("t5");
    imask = 1'b1; sci = 1'b1;
    tick("t5a"); tick("t5b");
    chk("t5_masked_req", {7'd0, int_req}, 8'h00);
    chk("t5_masked_wake", {7'd0, wake}, 8'h00);
    imask = 1'b0;
    tick("t5c");
    chk("t5_req", {7'd0, int_req}, 8'h01);
    chk("t5_vect", int_vect, 8'hF0);

    // 6: asynchronous reset during NMI lock
    do_reset("t6");
    nmi_pin = 1'b1;
    tick("t6a"); tick("t6b"); tick("t6c");
    ack_start = 1'b1;
    tick("t6d");
    chk("t6_lock_pend", {7'd0, nmi_pend}, 8'h01);
    nmi_pin = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_async_req",  {7'd0, int_req},  8'h00);
    chk("t6_async_vect", int_vect,         8'h00);
    chk("t6_async_pend", {7'd0, nmi_pend}, 8'h00);
    chk("t6_async_wake", {7'd0, wake},     8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      en = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 7) == 0) nmi_pin = ~nmi_pin;
      if ($urandom_range(0, 3) == 0) irq1_pin = ~irq1_pin;
      if ($urandom_range(0, 4) == 0) icf = ~icf;
      if ($urandom_range(0, 4) == 0) ocf = ~ocf;
      if ($urandom_range(0, 4) == 0) tof = ~tof;
      if ($urandom_range(0, 4) == 0) sci = ~sci;
      if ($urandom_range(0, 7) == 0) imask = ~imask;
      ack_start = ($urandom_range(0, 3) == 0);
      ack_done  = ($urandom_range(0, 3) == 0);
      tick("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
